// File: rtl/audio_pkg.sv
// audio_pkg: shared mode encoding, default widths and saturation helper for the audio path
package audio_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_GAIN   = 2'b01,
    MODE_MUTE   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  localparam int SAMPLE_W_DEF = 16;
  localparam int GAIN_FRAC_DEF = 6;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/audio_fifo.sv
// audio_fifo: synchronous FIFO with a register-array head and an occupancy count
module audio_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign valid = level != '0;
  // storage, pointers and level; callers never push on full or pop on empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/audio_path.sv
// audio_path: channel-tagging, per-frame effect pipeline feeding an output FIFO (AUDIO_PATH_STATS_EN adds drop_cnt)
module audio_path
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CHANNELS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int GAIN_W = 8,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [GAIN_W-1:0]   gain,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic [CH_W-1:0]     out_channel,
  input  logic                out_ready,
  output logic [LVL_W-1:0]    fifo_level
`ifdef AUDIO_PATH_STATS_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);
  localparam int P_W = SAMPLE_W + GAIN_W + 1;
  logic [CH_W-1:0] ch_cnt, s1_ch, s2_ch;
  mode_e mode_q, mode_eff, s1_mode;
  logic [GAIN_W-1:0] gain_q, gain_eff;
  logic accept, dropped, s1_v, s2_v;
  logic signed [P_W-1:0] s1_prod;
  logic [SAMPLE_W-1:0] s1_sample, s2_sample, gained, result;
  logic signed [63:0] rounded;
  logic [CH_W+SAMPLE_W-1:0] head;
  // the first sample of a frame uses the live controls, later ones the latched copy
  assign mode_eff = ch_cnt == '0 ? mode_e'(mode) : mode_q;
  assign gain_eff = ch_cnt == '0 ? gain : gain_q;
  // reserve a FIFO slot for every sample still in the pipeline so nothing can overflow
  assign in_ready = int'(fifo_level) + int'(s1_v) + int'(s2_v) < FIFO_DEPTH;
  assign accept = in_valid && in_ready;
  assign dropped = in_valid && !in_ready;
  // channel counter follows every strobe so frames stay aligned through drops
  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) begin
      ch_cnt <= '0;
      mode_q <= MODE_BYPASS;
      gain_q <= GAIN_W'(1 << GAIN_FRAC);
    end else if (in_valid) begin
      ch_cnt <= ch_cnt == CH_W'(CHANNELS - 1) ? '0 : ch_cnt + 1'b1;
      mode_q <= mode_eff;
      gain_q <= gain_eff;
    end
  // stage 1: multiply by the unsigned gain, carrying the raw sample, tag and mode
  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) begin
      s1_v <= 1'b0;
      s1_prod <= '0;
      s1_sample <= '0;
      s1_ch <= '0;
      s1_mode <= MODE_BYPASS;
    end else begin
      s1_v <= accept;
      s1_prod <= $signed(in_sample) * $signed({1'b0, gain_eff});
      s1_sample <= in_sample;
      s1_ch <= ch_cnt;
      s1_mode <= mode_eff;
    end
  // round half up, drop the fraction, clamp, then pick the effect for this frame
  always_comb begin
    rounded = ($signed({{(64 - P_W){s1_prod[P_W-1]}}, s1_prod}) + (64'sd1 <<< (GAIN_FRAC - 1))) >>> GAIN_FRAC;
    gained = SAMPLE_W'(saturate(rounded, SAMPLE_W));
    result = s1_mode == MODE_GAIN ? gained : s1_mode == MODE_MUTE ? '0 : s1_sample;
  end
  // stage 2: hold the finished sample for the FIFO write
  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) begin
      s2_v <= 1'b0;
      s2_sample <= '0;
      s2_ch <= '0;
    end else begin
      s2_v <= s1_v;
      s2_sample <= result;
      s2_ch <= s1_ch;
    end
  audio_fifo #(.W(CH_W + SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_25mhz),
    .rst_n(reset),
    .push(s2_v),
    .din({s2_ch, s2_sample}),
    .pop(out_valid && out_ready),
    .dout(head),
    .valid(out_valid),
    .level(fifo_level)
  );
  assign {out_channel, out_sample} = head;
`ifdef AUDIO_PATH_STATS_EN
  // saturating count of samples refused for lack of space
  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) drop_cnt <= '0;
    else if (dropped && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
`else
  logic unused_drop;
  assign unused_drop = dropped;
`endif
endmodule

// File: tb/tb_audio_path.sv
// tb_audio_path: randomized and directed checks of audio_path against an occupancy/queue model
module tb_audio_path;
  localparam int D = 8;
  localparam int CH = 2;
  logic clk_25mhz = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_sample = 0;
  logic [1:0] mode = 0;
  logic [7:0] gain = 64;
  logic in_ready, out_valid;
  logic [15:0] out_sample;
  logic [0:0] out_channel;
  logic [3:0] fifo_level;
`ifdef AUDIO_PATH_STATS_EN
  logic [15:0] drop_cnt;
`endif
  audio_path dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
    .in_ready(in_ready), .mode(mode), .gain(gain), .out_valid(out_valid),
    .out_sample(out_sample), .out_channel(out_channel), .out_ready(out_ready),
    .fifo_level(fifo_level)
`ifdef AUDIO_PATH_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct {logic [15:0] v; int ch; int avail;} ent_t;
  ent_t q[$];
  logic [16:0] seen[$];
  int compared = 0, mismatched = 0, cyc = 0;
  int m_ch, m_drops;
  logic [1:0] m_mode;
  logic [7:0] m_gain;

  function automatic logic [15:0] effect(input logic [1:0] md, input logic [7:0] g, input logic [15:0] s);
    longint p;
    if (md == 2'b10) return 16'h0000;
    if (md != 2'b01) return s;
    p = (longint'($signed(s)) * longint'(g) + 32) >>> 6;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  always @(posedge clk_25mhz) cyc++;

  // model: every accepted sample is queued with the cycle it becomes visible at the FIFO head
  always @(negedge clk_25mhz) begin
    int lvl;
    bit hv, acc, pop;
    if (!reset) begin
      q.delete();
      m_ch = 0; m_mode = 0; m_gain = 64; m_drops = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sample", out_sample, 0);
      check("rst_out_channel", out_channel, 0);
`ifdef AUDIO_PATH_STATS_EN
      check("rst_drop_cnt", drop_cnt, 0);
`endif
    end else begin
      lvl = 0;
      foreach (q[i]) if (q[i].avail <= cyc) lvl++;
      hv = lvl > 0;
      check("out_valid", out_valid, hv);
      check("fifo_level", fifo_level, lvl);
      check("in_ready", in_ready, q.size() < D);
      if (hv) begin
        check("out_sample", out_sample, q[0].v);
        check("out_channel", out_channel, q[0].ch);
      end
`ifdef AUDIO_PATH_STATS_EN
      check("drop_cnt", drop_cnt, m_drops);
`endif
      pop = hv && out_ready;
      acc = in_valid && q.size() < D;
      if (in_valid) begin
        if (m_ch == 0) begin m_mode = mode; m_gain = gain; end
        if (acc) q.push_back('{v: effect(m_mode, m_gain, in_sample), ch: m_ch, avail: cyc + 3});
        else if (m_drops < 65535) m_drops++;
        m_ch = (m_ch + 1) % CH;
      end
      if (pop) begin
        seen.push_back({1'(q[0].ch), q[0].v});
        void'(q.pop_front());
      end
    end
  end

  logic [15:0] ts[10] = '{16'h3000, 16'h5000, 16'hB000, 16'h0000, 16'h0003, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [1:0]  tm[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
  logic [7:0]  tg[10] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd96, 8'd96, 8'd64, 8'd64, 8'd64, 8'd64};
  logic [15:0] te[10] = '{16'h6000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0005, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 16'h0000};

  initial begin
    int base;
    check("pin_x2", effect(2'b01, 8'd128, 16'h3000), 16'h6000);
    check("pin_sat_hi", effect(2'b01, 8'd128, 16'h5000), 16'h7FFF);
    check("pin_sat_lo", effect(2'b01, 8'd128, 16'hB000), 16'h8000);
    check("pin_round", effect(2'b01, 8'd96, 16'h0003), 16'h0005);
    repeat (3) tick();
    reset = 1; out_ready = 1;
    tick();
    in_valid = 1; in_sample = 16'h1234; mode = 0; tick();
    in_sample = 16'h8000; tick();
    in_valid = 0;
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_s0", out_sample, 16'h1234);
    check("lat_c0", out_channel, 0);
    tick();
    check("lat_s1", out_sample, 16'h8000);
    check("lat_c1", out_channel, 1);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_sample = ts[i]; mode = tm[i]; gain = tg[i]; tick();
    end
    in_valid = 0; mode = 0; gain = 64;
    repeat (6) tick();
    check("seen_count", seen.size(), 12);
    if (seen.size() == 12) begin
      check("seen_bp0", seen[0], 17'h01234);
      check("seen_bp1", seen[1], 17'h18000);
      for (int i = 0; i < 10; i++) check($sformatf("seen_fx%0d", i), seen[i + 2], {1'(i % 2), te[i]});
    end
    out_ready = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_sample = 16'hA000 + 16'(i); tick();
    end
    in_valid = 0;
    repeat (3) tick();
    check("bp_level", fifo_level, 8);
    check("bp_ready", in_ready, 0);
`ifdef AUDIO_PATH_STATS_EN
    check("bp_drops", drop_cnt, 4);
`endif
    base = seen.size();
    out_ready = 1;
    repeat (12) tick();
    check("bp_count", seen.size(), base + 8);
    if (seen.size() == base + 8)
      for (int i = 0; i < 8; i++) check($sformatf("bp_order%0d", i), seen[base + i], {1'(i % 2), 16'hA000 + 16'(i)});
    for (int i = 0; i < 14; i++) begin
      in_valid = 1; in_sample = 16'hC000 + 16'(i); out_ready = i >= 6; tick();
      if (i >= 6) check("pushpop_level", fifo_level, 4);
    end
    in_valid = 0; out_ready = 1;
    repeat (12) tick();
    out_ready = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_sample = 16'hD000 + 16'(i); tick();
    end
    in_valid = 0;
    check("pre_rst_level", fifo_level, 5);
    reset = 0;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", in_ready, 1);
    tick();
    reset = 1; out_ready = 1;
    tick();
    in_valid = 1; in_sample = 16'h7777; mode = 0; tick();
    in_valid = 0;
    repeat (5) tick();
    check("post_rst_tag", seen[$], 17'h07777);
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_sample = 16'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      gain = 8'($urandom);
      out_ready = $urandom_range(0, 9) < 6;
      reset = i != 1500;
      tick();
    end
    in_valid = 0; out_ready = 1; reset = 1;
    repeat (20) tick();
    check("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/audio_path.md
# audio_path

Parametrised, multi-channel audio datapath between the SPI sample receiver and the DAC driver. It accepts interleaved PCM samples, tags each with its channel, applies a per-frame selectable effect (bypass, fixed-point gain with saturation, mute), and buffers results in a FIFO with a valid/ready output toward the DAC side. It replaces the single hard-wired effect-plus-reset-mux path with a generalised width, channel count, buffering and mode control.

## Interface
- SAMPLE_W, 16, signed PCM sample width
- CHANNELS, 2, interleaved channels per frame (≥1)
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥4)
- GAIN_W, 8, unsigned gain width
- GAIN_FRAC, 6, fractional bits of gain (unity = 2^GAIN_FRAC)

- clk_25mhz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe from receiver (one-cycle pulse)
- in_sample  in  SAMPLE_W  signed sample
- in_ready  out  1  space available for one more sample
- mode  in  2  00 bypass, 01 gain, 10 mute, 11 treated as bypass
- gain  in  GAIN_W  unsigned gain, used in mode 01
- out_valid  out  1  FIFO head valid
- out_sample  out  SAMPLE_W  FIFO head sample
- out_channel  out  $clog2(CHANNELS) (min 1)  channel of head sample
- out_ready  in  1  DAC side consumes head when high with out_valid
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored
- drop_cnt  out  16  dropped-sample counter (only with AUDIO_PATH_STATS_EN)

## Operation
- Receiver has no backpressure: a sample with in_valid=1 and in_ready=0 is dropped, never stalls.
- Channel counter ch_cnt advances on every in_valid (accepted or dropped), wraps CHANNELS-1 → 0; keeps frame alignment through drops.
- Mode/gain latch: mode_q/gain_q capture mode/gain on in_valid when ch_cnt==0; all samples of a frame use the same setting. Change mid-frame takes effect at next frame start.
- Stage 1 (registered): product = in_sample × {1'b0,gain_q}, width SAMPLE_W+GAIN_W+1, signed; channel tag and mode carried.
- Stage 2 (registered): gain mode: (product + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, saturate to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1]; bypass: original sample unchanged; mute: 0. Result written to FIFO.
- in_ready = (fifo_level + stages occupied) < FIFO_DEPTH; guarantees every accepted sample has a FIFO slot, no overflow possible.
- FIFO: pop when out_valid && out_ready; simultaneous push and pop leaves level unchanged; pop on empty / push on full impossible by construction.

## Timing
- Reset values: out_valid 0, out_sample 0, out_channel 0, fifo_level 0, drop_cnt 0, ch_cnt 0, mode_q 00, gain_q 2^GAIN_FRAC, pipeline empty; in_ready 1.
- Latency: sample accepted at edge k → stage 1 at k, stage 2 at k+1, FIFO write at k+2, out_valid high after edge k+2 when FIFO was empty (registered head).
- Throughput: one sample per cycle.
- out_sample/out_channel stable while out_valid && !out_ready.
- Reset asserted mid-operation: pipeline, FIFO, counters cleared immediately; in-flight samples discarded; ch_cnt restarts at 0.
- drop_cnt saturates at 16'hFFFF.

## Configuration
- AUDIO_PATH_STATS_EN defined: drop_cnt port present, increments by 1 per dropped sample, saturating.
- Not defined: drop_cnt port and counter absent; drops still occur silently, all other behaviour identical.

## Structure
- Package audio_pkg: mode enum (MODE_BYPASS, MODE_GAIN, MODE_MUTE, MODE_RSVD), default SAMPLE_W/GAIN_FRAC constants, saturate function.
- One sub-module: audio_fifo (synchronous FIFO, parametrised width/depth, registered head, level output); data = {channel, sample}.

## Test plan
- Bypass, CHANNELS=2: samples 0x1234, 0x8000 with out_ready=1 → out (0x1234, ch0) 3 cycles after accept, then (0x8000, ch1).
- Gain mode, gain=128 (×2): in 0x3000 → 0x6000; in 0x5000 → 0x7FFF saturated; in 0xB000 → 0x8000 saturated; gain=96 on 0x0003 → 0x0005 (4.5 rounded up).
- Mode switch from bypass to mute while ch_cnt==1 → remaining ch1 sample passes unchanged; next frame ch0 and ch1 output 0x0000.
- out_ready=0, back-to-back in_valid → in_ready falls when level+inflight = 8; further samples dropped, drop_cnt counts them (with AUDIO_PATH_STATS_EN), ch_cnt keeps alternating; release out_ready → exactly 8 samples emerge in order with correct channels.
- Simultaneous push and pop at level 4 → fifo_level stays 4, order preserved.
- Reset asserted with FIFO at level 5 → next cycle out_valid 0, fifo_level 0, in_ready 1; first post-reset sample tagged ch0.
